// File: rtl/noc_credit_pkt_buffer_if.sv
// Flit transport bundle for noc_credit_pkt_buffer.
//   noc_in_val / noc_in_dat   : credit-based ingress flit; noc_in_yummy returns one credit per pulse
//   noc_out_val / noc_out_rdy : val/rdy egress handshake
//   noc_out_dat               : egress flit
//   noc_out_hdr / noc_out_last: framing of the egress flit
// slave  : the buffer side (consumes ingress, produces egress)
// master : the environment side (upstream sender plus downstream sink)
interface noc_credit_pkt_buffer_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();

  logic                  noc_in_val;
  logic [DATA_WIDTH-1:0] noc_in_dat;
  logic                  noc_in_yummy;
  logic                  noc_out_val;
  logic [DATA_WIDTH-1:0] noc_out_dat;
  logic                  noc_out_rdy;
  logic                  noc_out_hdr;
  logic                  noc_out_last;

  modport slave (
    input  noc_in_val,
    input  noc_in_dat,
    output noc_in_yummy,
    output noc_out_val,
    output noc_out_dat,
    input  noc_out_rdy,
    output noc_out_hdr,
    output noc_out_last
  );

  modport master (
    output noc_in_val,
    output noc_in_dat,
    input  noc_in_yummy,
    input  noc_out_val,
    input  noc_out_dat,
    output noc_out_rdy,
    input  noc_out_hdr,
    input  noc_out_last
  );

endinterface

// File: rtl/noc_credit_pkt_buffer.sv
// Credit-to-val/rdy NoC flit buffer with packet framing.
// Accepts flits from a credit-based sender, stores up to DEPTH of them, and presents them on a
// val/rdy interface. Every pop returns one credit (registered yummy). A small FSM follows the head
// flit to mark headers and the last flit of each packet; packets may be longer than DEPTH.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   noc          : flit bundle (slave modport)
//   occupancy    : flits currently buffered, 0..DEPTH
//   overflow_err : sticky; set when a flit arrives while full with no pop in the same cycle
module noc_credit_pkt_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LEN_LSB    = 22,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  noc_credit_pkt_buffer_if.slave   noc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic StHdr  = 1'b0;
  localparam logic StBody = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [CntW-1:0]       occ_q, occ_d;
  logic                  state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  ovf_q, ovf_d;
  logic                  yummy_q;

  logic                  full, empty, push, pop, drop;
  logic [DATA_WIDTH-1:0] head_flit;
  logic [LEN_WIDTH-1:0]  head_len;

  always_comb begin
    full      = (occ_q == CntW'(DEPTH));
    empty     = (occ_q == '0);
    pop       = !empty && noc.noc_out_rdy;
    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    push      = noc.noc_in_val && (!full || pop);
    drop      = noc.noc_in_val && full && !pop;
    head_flit = mem_q[head_q];
    head_len  = head_flit[LEN_LSB +: LEN_WIDTH];
  end

  // Pointers, occupancy and error flag.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q | drop;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Framing FSM: advances only on pops, so it is independent of how much is buffered.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (pop) begin
      if (state_q == StHdr) begin
        if (head_len != '0) begin
          rem_d   = head_len;
          state_d = StBody;
        end
      end else begin
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_WIDTH'(1)) state_d = StHdr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      state_q <= StHdr;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      yummy_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      yummy_q <= pop;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[tail_q] <= noc.noc_in_dat;
  end

  always_comb begin
    noc.noc_in_yummy = yummy_q;
    noc.noc_out_val  = !empty;
    noc.noc_out_dat  = head_flit;
    noc.noc_out_hdr  = !empty && (state_q == StHdr);
    if (empty) begin
      noc.noc_out_last = 1'b0;
    end else if (state_q == StHdr) begin
      noc.noc_out_last = (head_len == '0);
    end else begin
      noc.noc_out_last = (rem_q == LEN_WIDTH'(1));
    end
    occupancy    = occ_q;
    overflow_err = ovf_q;
  end

endmodule
